// File: rtl/stage_sequencer_if.sv
// -----------------------------------------------------------------------------
// stage_sequencer_if
// Signal bundle between the TinyCPU stage sequencer and its surroundings
// (main memory, decoder, branch unit, core control).
//
// Default encodings for the stage and instruction-type macros are provided
// here, guarded, so the block builds stand-alone. When arch_defines.v is
// compiled first, its definitions take precedence.
//
// Modports:
//   master : the sequencer. Inputs run, mem_ready, read_data,
//            current_instr_type, branch_taken, branch_target. Outputs stage,
//            PC_value, instr_reg, halted, retired_count.
//   slave  : the environment, with the opposite directions.
// -----------------------------------------------------------------------------
`ifndef STAGE_WIDTH
`define STAGE_WIDTH 3
`endif
`ifndef STAGE_IDLE
`define STAGE_IDLE 3'd0
`endif
`ifndef STAGE_FETCH
`define STAGE_FETCH 3'd1
`endif
`ifndef STAGE_DECODE
`define STAGE_DECODE 3'd2
`endif
`ifndef STAGE_EXECUTE
`define STAGE_EXECUTE 3'd3
`endif
`ifndef STAGE_MEMORY
`define STAGE_MEMORY 3'd4
`endif
`ifndef STAGE_WRITEBACK
`define STAGE_WRITEBACK 3'd5
`endif
`ifndef STAGE_HALTED
`define STAGE_HALTED 3'd6
`endif
`ifndef INSTR_ALU
`define INSTR_ALU 5'd0
`endif
`ifndef INSTR_LOAD
`define INSTR_LOAD 5'd1
`endif
`ifndef INSTR_STORE
`define INSTR_STORE 5'd2
`endif
`ifndef INSTR_HALT
`define INSTR_HALT 5'd31
`endif

interface stage_sequencer_if;
  logic                    run;
  logic                    mem_ready;
  logic [31:0]             read_data;
  logic [4:0]              current_instr_type;
  logic                    branch_taken;
  logic [31:0]             branch_target;
  logic [`STAGE_WIDTH-1:0] stage;
  logic [31:0]             PC_value;
  logic [31:0]             instr_reg;
  logic                    halted;
  logic [31:0]             retired_count;

  modport master (
    input  run, mem_ready, read_data, current_instr_type, branch_taken, branch_target,
    output stage, PC_value, instr_reg, halted, retired_count
  );

  modport slave (
    output run, mem_ready, read_data, current_instr_type, branch_taken, branch_target,
    input  stage, PC_value, instr_reg, halted, retired_count
  );
endinterface

// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
// Multi-cycle control sequencer for the TinyCPU core. It owns the program
// counter, the instruction register and the current stage, and steps each
// instruction through FETCH, DECODE, EXECUTE, optional MEMORY and WRITEBACK.
// It stalls in FETCH and MEMORY until main memory reports mem_ready.
//
// Ports:
//   clk    : core clock, rising-edge active
//   rst_n  : asynchronous active-low reset
//   bus    : stage_sequencer_if.master (control inputs, memory handshake,
//            and the stage / PC_value / instr_reg / halted / retired_count
//            outputs)
// Parameter:
//   RESET_PC : PC value loaded on reset
//
// Build option:
//   STAGE_SEQ_RETIRE_COUNT_EN : when defined, retired_count is a live 32-bit
//   wrapping counter. When undefined, no counter is built and retired_count
//   reads 32'h0.
// -----------------------------------------------------------------------------
module stage_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  stage_sequencer_if.master  bus
);

  typedef enum logic [`STAGE_WIDTH-1:0] {
    ST_IDLE      = `STAGE_IDLE,
    ST_FETCH     = `STAGE_FETCH,
    ST_DECODE    = `STAGE_DECODE,
    ST_EXECUTE   = `STAGE_EXECUTE,
    ST_MEMORY    = `STAGE_MEMORY,
    ST_WRITEBACK = `STAGE_WRITEBACK,
    ST_HALTED    = `STAGE_HALTED
  } stage_t;

  stage_t      state_r;
  stage_t      state_s;
  logic [31:0] pc_r;
  logic [31:0] pc_s;
  logic [31:0] ir_r;
  logic [31:0] ir_s;
  logic        halted_r;
  logic        retire_s;

  // Next-state, next-PC, next-IR and retire-strobe logic
  always_comb begin
    state_s  = state_r;
    pc_s     = pc_r;
    ir_s     = ir_r;
    retire_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.run) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (bus.mem_ready) begin
          state_s = ST_DECODE;
          ir_s    = bus.read_data;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        state_s = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (bus.current_instr_type == `INSTR_HALT) begin
          // A halt retires here; it never visits WRITEBACK.
          state_s  = ST_HALTED;
          pc_s     = pc_r + 32'd4;
          retire_s = 1'b1;
        end else if ((bus.current_instr_type == `INSTR_LOAD) ||
                     (bus.current_instr_type == `INSTR_STORE)) begin
          state_s = ST_MEMORY;
        end else begin
          state_s = ST_WRITEBACK;
        end
      end
      ST_MEMORY: begin
        if (bus.mem_ready) begin
          state_s = ST_WRITEBACK;
        end else begin
          state_s = ST_MEMORY;
        end
      end
      ST_WRITEBACK: begin
        // Misaligned targets are silently word-aligned.
        if (bus.branch_taken) begin
          pc_s = bus.branch_target & 32'hFFFF_FFFC;
        end else begin
          pc_s = pc_r + 32'd4;
        end
        retire_s = 1'b1;
        state_s  = ST_FETCH;
      end
      ST_HALTED: begin
        if (bus.run) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_HALTED;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Stage, PC, instruction register and halted flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      pc_r     <= RESET_PC;
      ir_r     <= 32'h0000_0000;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      ir_r     <= ir_s;
      halted_r <= (state_s == ST_HALTED);
    end
  end

`ifdef STAGE_SEQ_RETIRE_COUNT_EN
  logic [31:0] retired_r;

  // Retired-instruction counter, wrapping modulo 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_r <= 32'h0000_0000;
    end else if (retire_s) begin
      retired_r <= retired_r + 32'd1;
    end else begin
      retired_r <= retired_r;
    end
  end

  assign bus.retired_count = retired_r;
`else
  logic unused_retire_s;
  assign unused_retire_s   = retire_s;
  assign bus.retired_count = 32'h0000_0000;
`endif

  assign bus.stage     = state_r;
  assign bus.PC_value  = pc_r;
  assign bus.instr_reg = ir_r;
  assign bus.halted    = halted_r;

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Multi-cycle control sequencer for the TinyCPU core. Owns the program counter, the instruction register and the current pipeline stage. Its `stage` and `PC_value` outputs drive the main memory address/write-enable mux directly downstream. Steps each instruction through FETCH, DECODE, EXECUTE, optional MEMORY, and WRITEBACK, stalling on main memory readiness.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- run  input  1  start/resume pulse; honoured only in STAGE_IDLE or STAGE_HALTED.
- mem_ready  input  1  main memory has completed the access presented this cycle.
- read_data  input  32  main memory read data; sampled in FETCH.
- current_instr_type  input  5  decoded type of `instr_reg` (`INSTR_*` from arch_defines.v); valid from DECODE onward.
- branch_taken  input  1  redirect PC; sampled only in WRITEBACK.
- branch_target  input  32  redirect address; sampled only in WRITEBACK.
- stage  output  `STAGE_WIDTH  current stage (`STAGE_*` encodings).
- PC_value  output  32  address of the instruction in flight.
- instr_reg  output  32  latched instruction word.
- halted  output  1  high while in STAGE_HALTED.
- retired_count  output  32  instructions retired since reset.

## Operation
- Reset values: stage=`STAGE_IDLE`, PC_value=RESET_PC, instr_reg=0, halted=0, retired_count=0.
- IDLE: `run`=1 -> FETCH; otherwise hold.
- FETCH: `mem_ready`=1 -> instr_reg<=read_data, -> DECODE; otherwise hold (instr_reg unchanged).
- DECODE: -> EXECUTE unconditionally.
- EXECUTE:
  - type == `INSTR_HALT` -> HALTED; PC<=PC+4; retire.
  - type == `INSTR_LOAD` or `INSTR_STORE` -> MEMORY.
  - otherwise -> WRITEBACK.
- MEMORY: `mem_ready`=1 -> WRITEBACK; otherwise hold. The downstream write_enable stays asserted for every MEMORY cycle of a store; memory tolerates repeated identical writes.
- WRITEBACK: PC<=branch_taken ? {branch_target[31:2],2'b00} : PC+4; retire; -> FETCH.
- HALTED: `run`=1 -> FETCH at the current PC; otherwise hold. halted=1 only in this state.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0. Misaligned branch targets have bits [1:0] cleared, with no fault.
- `run` in any other stage is ignored. An unrecognised stage encoding recovers to IDLE.
- Retire increments retired_count by 1, wrapping from 32'hFFFF_FFFF to 0.

## Timing
- All outputs are registered and change only on the clk edge or on the rst_n assertion.
- Minimum instruction latency with `mem_ready` tied high: 4 cycles for non-memory instructions, 5 cycles for load/store.
- Each low cycle of `mem_ready` in FETCH or MEMORY adds exactly one cycle.
- A `run` pulse in IDLE gives stage=FETCH on the next edge.
- PC_value and retired_count update on the edge leaving WRITEBACK (or EXECUTE for a halt) and are visible in the following FETCH/HALTED cycle.
- rst_n low at any time, including mid-MEMORY with mem_ready low, forces reset values immediately. No memory transaction is completed or replayed.
- Release of rst_n is synchronised externally. The first active edge after release starts evaluation from IDLE.

## Configuration
- `STAGE_SEQ_RETIRE_COUNT_EN` defined: retired_count is a live 32-bit counter as described.
- Undefined: the counter register is not built and retired_count is tied to 32'h0. All other behaviour is identical.

## Test plan
- Reset: assert rst_n=0 mid-run with RESET_PC=32'h40 -> stage=IDLE, PC_value=32'h40, instr_reg=0, halted=0, retired_count=0 with no clock edge.
- ALU instruction, mem_ready=1, `run` pulse at cycle 0 -> stage sequence FETCH, DECODE, EXECUTE, WRITEBACK, FETCH; PC 0->4 on entering FETCH; retired_count=1.
- Fetch stall: mem_ready low 3 cycles, read_data=32'hDEAD_BEEF -> FETCH held 4 cycles; instr_reg=32'hDEAD_BEEF after the 4th edge.
- Store with mem_ready low 2 cycles in MEMORY -> MEMORY held 3 cycles, then WRITEBACK; PC+4.
- Branch: WRITEBACK with branch_taken=1, target=32'h103 -> next PC=32'h100. With PC=32'hFFFF_FFFC and no branch -> PC=0.
- Halt then `run` -> HALTED with halted=1 and PC=old+4; `run` ignored mid-EXECUTE; `run` in HALTED -> FETCH at that PC. With the macro undefined, retired_count stays 0 throughout.
